// File: rtl/uart_tx_pkg.sv
// Shared definitions for the memory-mapped UART transmitter: register map,
// STATUS bit layout and transmitter state encoding.
package uart_tx_pkg;

    localparam logic [3:0] OFF_TXDATA  = 4'd0;
    localparam logic [3:0] OFF_STATUS  = 4'd4;
    localparam logic [3:0] OFF_DROPCNT = 4'd8;

    localparam int STAT_FULL    = 0;
    localparam int STAT_EMPTY   = 1;
    localparam int STAT_ACTIVE  = 2;
    localparam int STAT_CNT_LSB = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; a push while full is accepted
// only when a pop happens at the same edge.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     push,
    input  logic [WIDTH-1:0]         din,
    input  logic                     pop,
    output logic [WIDTH-1:0]         dout,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      r_wr_ptr;
    logic [AW:0]      r_rd_ptr;
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic             w_do_push;
    logic             w_do_pop;

    assign empty     = (r_wr_ptr == r_rd_ptr);
    assign full      = (r_wr_ptr[AW] != r_rd_ptr[AW]) &&
                       (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign count     = r_wr_ptr - r_rd_ptr;
    assign dout      = r_mem[r_rd_ptr[AW-1:0]];
    assign w_do_pop  = pop & ~empty;
    assign w_do_push = push & (~full | w_do_pop);

    // NOTE: non-blocking assignments for all state so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    // NOTE: storage is not reset; the pointers alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= din;
    end

endmodule

// File: rtl/mmio_uart_tx.sv
// Memory-mapped 8N1 UART transmitter snooping the core's store stream:
// TXDATA feeds a byte FIFO, STATUS and DROPCNT report FIFO and overflow state.
module mmio_uart_tx
    import uart_tx_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR    = 32'h8000_0000,
    parameter int          CLKS_PER_BIT = 16,
    parameter int          FIFO_DEPTH   = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        mem_write,
    input  logic [31:0] data_addr,
    input  logic [31:0] write_data,
    output logic        sel,
    output logic [31:0] rd_data,
    output logic        tx,
    output logic        busy
);
    localparam int                CW        = $clog2(FIFO_DEPTH) + 1;
    localparam int                BW        = $clog2(CLKS_PER_BIT);
    localparam logic [BW-1:0]     BAUD_LAST = BW'(CLKS_PER_BIT - 1);

    logic [29:0]   w_word_off;
    logic [3:0]    w_reg_off;
    logic          w_push;
    logic          w_clr;
    logic          w_pop;
    logic          w_drop;
    logic          w_full;
    logic          w_empty;
    logic [CW-1:0] w_count;
    logic [7:0]    w_fifo_dout;
    logic [31:0]   w_status;
    logic          w_baud_last;
    logic          w_unused_bits;

    tx_state_e     r_state;
    logic [BW-1:0] r_baud;
    logic [2:0]    r_bit;
    logic [7:0]    r_shift;
    logic          r_tx;
    logic [15:0]   r_drop;

    // Word-granular window: offset within the window, byte lanes ignored.
    assign w_word_off    = data_addr[31:2] - BASE_ADDR[31:2];
    assign sel           = (w_word_off < 30'd3);
    assign w_reg_off     = {w_word_off[1:0], 2'b00};
    assign w_push        = mem_write & sel & (w_reg_off == OFF_TXDATA);
    assign w_clr         = mem_write & sel & (w_reg_off == OFF_DROPCNT);
    assign w_baud_last   = (r_baud == BAUD_LAST);
    assign w_pop         = ~w_empty & ((r_state == IDLE) | ((r_state == STOP) & w_baud_last));
    assign w_drop        = w_push & w_full & ~w_pop;
    assign w_unused_bits = ^{data_addr[1:0], write_data[31:8]};

    sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (w_push),
        .din   (write_data[7:0]),
        .pop   (w_pop),
        .dout  (w_fifo_dout),
        .full  (w_full),
        .empty (w_empty),
        .count (w_count)
    );

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        w_status               = '0;
        w_status[STAT_FULL]    = w_full;
        w_status[STAT_EMPTY]   = w_empty;
        w_status[STAT_ACTIVE]  = (r_state != IDLE);
        w_status[STAT_CNT_LSB +: 8] = 8'(w_count);
    end

    always_comb begin
        rd_data = '0;
        if (sel) begin
            case (w_reg_off)
                OFF_STATUS:  rd_data = w_status;
                OFF_DROPCNT: rd_data = {16'b0, r_drop};
                default:     rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset)                             r_drop <= '0;
        else if (w_clr)                        r_drop <= '0;
        else if (w_drop && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
    end

    // tx is driven with the value of the state being entered, so it stays registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    r_tx <= 1'b1;
                    if (w_pop) begin
                        r_shift <= w_fifo_dout;
                        r_bit   <= '0;
                        r_baud  <= '0;
                        r_state <= START;
                        r_tx    <= 1'b0;
                    end
                end
                START: begin
                    if (w_baud_last) begin
                        r_baud  <= '0;
                        r_state <= DATA;
                        r_tx    <= r_shift[0];
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                DATA: begin
                    if (w_baud_last) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            r_state <= STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_bit   <= r_bit + 3'd1;
                            r_shift <= r_shift >> 1;
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                STOP: begin
                    if (w_baud_last) begin
                        r_baud <= '0;
                        if (w_pop) begin
                            r_shift <= w_fifo_dout;
                            r_bit   <= '0;
                            r_state <= START;
                            r_tx    <= 1'b0;
                        end else begin
                            r_state <= IDLE;
                            r_tx    <= 1'b1;
                        end
                    end else begin
                        r_baud <= r_baud + 1'b1;
                    end
                end
                default: begin
                    r_state <= IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign tx   = r_tx;
    assign busy = (r_state != IDLE) | ~w_empty;

endmodule

// File: tb/tb_mmio_uart_tx.sv
// Randomized bench for mmio_uart_tx against a frame-timeline reference model
// (byte queue plus position within the current frame).
module tb_mmio_uart_tx;

    localparam logic [31:0] BASE  = 32'h8000_0000;
    localparam int          CPB   = 4;
    localparam int          DEPTH = 8;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        mem_write = 1'b0;
    logic [31:0] data_addr = '0;
    logic [31:0] write_data = '0;
    logic        sel;
    logic [31:0] rd_data;
    logic        tx;
    logic        busy;

    int n_chk = 0;
    int n_err = 0;

    logic [7:0] m_q[$];
    bit         m_active = 1'b0;
    int         m_pos = 0;
    logic [7:0] m_cur = '0;
    int         m_drop = 0;

    mmio_uart_tx #(.BASE_ADDR(BASE), .CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
        .clk        (clk),
        .reset      (reset),
        .mem_write  (mem_write),
        .data_addr  (data_addr),
        .write_data (write_data),
        .sel        (sel),
        .rd_data    (rd_data),
        .tx         (tx),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] m_status();
        logic [31:0] s = '0;
        s[0]    = (m_q.size() == DEPTH);
        s[1]    = (m_q.size() == 0);
        s[2]    = m_active;
        s[15:8] = 8'(m_q.size());
        return s;
    endfunction

    function automatic bit m_in_window(input logic [31:0] a);
        return (a >= BASE) && (a < BASE + 32'd12);
    endfunction

    function automatic logic [31:0] m_read(input logic [31:0] a);
        logic [31:0] off = a - BASE;
        if (!m_in_window(a)) return '0;
        if (off < 32'd4)     return '0;
        if (off < 32'd8)     return m_status();
        return 32'(m_drop);
    endfunction

    function automatic logic m_tx();
        int b;
        if (!m_active) return 1'b1;
        b = m_pos / CPB;
        if (b == 0) return 1'b0;
        if (b <= 8) return m_cur[b-1];
        return 1'b1;
    endfunction

    // Advance the model by one rising edge.
    task automatic model_edge(input logic we, input logic [31:0] a, input logic [31:0] d, input logic rst);
        int  pre_size;
        bit  popped;
        logic [31:0] off;
        if (rst) begin
            m_q.delete();
            m_active = 1'b0;
            m_pos    = 0;
            m_drop   = 0;
            return;
        end
        pre_size = m_q.size();
        popped   = 1'b0;
        if (m_active) begin
            m_pos++;
            if (m_pos == 10 * CPB) begin
                if (pre_size > 0) begin
                    m_cur  = m_q.pop_front();
                    m_pos  = 0;
                    popped = 1'b1;
                end else begin
                    m_active = 1'b0;
                end
            end
        end else if (pre_size > 0) begin
            m_cur    = m_q.pop_front();
            m_active = 1'b1;
            m_pos    = 0;
            popped   = 1'b1;
        end
        if (we && m_in_window(a)) begin
            off = a - BASE;
            if (off < 32'd4) begin
                if (pre_size < DEPTH || popped) m_q.push_back(d[7:0]);
                else if (m_drop < 16'hFFFF)     m_drop++;
            end else if (off >= 32'd8) begin
                m_drop = 0;
            end
        end
    endtask

    // One clock cycle: drive after negedge, check comb outputs, clock, check registered outputs.
    task automatic cycle(input logic we, input logic [31:0] a, input logic [31:0] d, input logic rst);
        reset      = rst;
        mem_write  = we;
        data_addr  = a;
        write_data = d;
        #1;
        check("sel", 32'(sel), 32'(m_in_window(a)));
        check("rd_data", rd_data, m_read(a));
        @(posedge clk);
        model_edge(we, a, d, rst);
        @(negedge clk);
        check("tx", 32'(tx), 32'(m_tx()));
        check("busy", 32'(busy), 32'(m_active || m_q.size() > 0));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, BASE + 32'd4, '0, 1'b0);
    endtask

    task automatic peek(input string tag, input logic [31:0] a, input logic [31:0] exp);
        mem_write = 1'b0;
        data_addr = a;
        #1;
        check(tag, rd_data, exp);
    endtask

    function automatic logic [31:0] rand_addr();
        case ($urandom_range(0, 7))
            0, 1, 2: return BASE;
            3:       return BASE + 32'd4;
            4:       return BASE + 32'd8;
            5:       return BASE + 32'd3;
            6:       return BASE + 32'd12;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        bit reached;
        @(negedge clk);
        cycle(1'b0, '0, '0, 1'b1);
        cycle(1'b0, '0, '0, 1'b1);
        peek("reset_status", BASE + 32'd4, 32'h0000_0002);
        check("reset_tx", 32'(tx), 32'h1);

        // Single byte 0x55
        cycle(1'b1, BASE, 32'h0000_0155, 1'b0);
        idle(42);
        check("single_done_busy", 32'(busy), 32'h0);

        // Back-to-back frames
        cycle(1'b1, BASE, 32'h41, 1'b0);
        cycle(1'b1, BASE, 32'h42, 1'b0);
        cycle(1'b1, BASE, 32'h43, 1'b0);
        peek("b2b_count", BASE + 32'd4, 32'h0000_0204);
        idle(125);

        // Overflow: one frame in flight, then ten more stores
        cycle(1'b1, BASE, 32'h10, 1'b0);
        idle(1);
        for (int i = 0; i < 10; i++) cycle(1'b1, BASE, 32'h20 + i, 1'b0);
        peek("ovf_status", BASE + 32'd4, 32'h0000_0805);
        peek("ovf_drop", BASE + 32'd8, 32'd2);
        cycle(1'b1, BASE + 32'd8, 32'h0, 1'b0);
        peek("drop_cleared", BASE + 32'd8, 32'd0);

        // Full FIFO with a pop at the end of STOP: the store in that cycle is accepted
        reached = 1'b0;
        for (int i = 0; i < 100 && !reached; i++) begin
            if (m_active && m_pos == 10 * CPB - 1 && m_q.size() == DEPTH) reached = 1'b1;
            else idle(1);
        end
        check("fullpop_reached", 32'(reached), 32'h1);
        cycle(1'b1, BASE, 32'hA5, 1'b0);
        peek("fullpop_status", BASE + 32'd4, 32'h0000_0805);
        peek("fullpop_drop", BASE + 32'd8, 32'd0);
        idle(9 * 10 * CPB + 5);
        check("drain_busy", 32'(busy), 32'h0);

        // Decode
        cycle(1'b1, BASE + 32'd4, 32'h12, 1'b0);
        cycle(1'b1, BASE + 32'd12, 32'h34, 1'b0);
        cycle(1'b1, 32'h0, 32'h56, 1'b0);
        cycle(1'b0, BASE + 32'd3, 32'h0, 1'b0);
        check("decode_busy", 32'(busy), 32'h0);

        // Reset mid-frame
        cycle(1'b1, BASE, 32'hC3, 1'b0);
        idle(15);
        cycle(1'b1, BASE, 32'h99, 1'b1);
        check("midrst_tx", 32'(tx), 32'h1);
        check("midrst_busy", 32'(busy), 32'h0);
        peek("midrst_status", BASE + 32'd4, 32'h0000_0002);
        cycle(1'b1, BASE, 32'h3C, 1'b0);
        idle(45);

        // Randomized traffic
        for (int i = 0; i < 2000; i++) begin
            cycle($urandom_range(0, 99) < 30, rand_addr(), $urandom,
                  $urandom_range(0, 499) == 0);
        end
        idle((DEPTH + 1) * 10 * CPB + 5);
        check("final_busy", 32'(busy), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
